dbus_arbiter: RTL
=================

# dbus_arbiter

Two-master arbiter that shares the single data-memory port (addr/wdata/byteen out, combinational rdata in) between the CPU's M-stage load/store port and a secondary bus master (DMA/debug engine). It sits between the `mips` core's data port and the data memory, decides one owner per cycle, and raises a stall to the CPU when the CPU loses arbitration. Bounded latency comes from starvation counters and a capped DMA burst lock.

## Interface
- `STARVE_LIMIT`, default 4: waiting cycles after which a requester is forced to win (≥1).
- `BURST_MAX`, default 8: maximum beats in one locked DMA tenure (≥1).
- One clock; reset is synchronous and active-high (ports `clk`, `reset`).
- `clk` in 1: system clock, all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU M-stage has a load/store this cycle.
- `cpu_addr` in 32, `cpu_wdata` in 32, `cpu_byteen` in 4: CPU access; byteen 0 means load.
- `cpu_rdata` out 32: `mem_rdata` while the CPU is granted, else 0.
- `cpu_stall` out 1: `cpu_req & ~cpu_gnt`; the CPU freezes while high.
- `dma_req` in 1, `dma_lock` in 1: DMA access; lock requests the next beat as well.
- `dma_addr` in 32, `dma_wdata` in 32, `dma_byteen` in 4: DMA access.
- `dma_gnt` out 1: DMA owns the port this cycle.
- `dma_rdata` out 32: `mem_rdata` while DMA is granted, else 0.
- `mem_addr` out 32, `mem_wdata` out 32, `mem_byteen` out 4: to memory; all 0 when no owner.
- `mem_rdata` in 32: combinational read data from memory.
- `owner` out 1: registered owner of the previous granted cycle (0 = CPU, 1 = DMA), for debug.

## Operation
- Registered state: `cpu_wait`, `dma_wait` (0..STARVE_LIMIT, saturating), `beat_cnt` (0..BURST_MAX), `lock_active`, `owner`.
- Grant priority is evaluated each cycle, and the first matching rule wins:
  1. `reset` = 1: no grant.
  2. `cpu_req` and `cpu_wait == STARVE_LIMIT`: CPU.
  3. `dma_req` and `lock_active`: DMA.
  4. `dma_req` and `dma_wait == STARVE_LIMIT`: DMA.
  5. `cpu_req`: CPU.
  6. `dma_req`: DMA.
  7. Otherwise: no owner, and `mem_byteen` = 0.
- `mem_*` mirror the granted master's `addr`/`wdata`/`byteen` unmodified. The memory performs alignment.
- Counter updates:
  - `cpu_wait`: cleared if `!cpu_req` or the CPU is granted; otherwise +1, saturating at STARVE_LIMIT.
  - `dma_wait`: same rule against `dma_req` / DMA grant.
- Beat counting when DMA is granted:
  - `beat_cnt_n` = `lock_active ? beat_cnt+1 : 1`.
  - `lock_active_n` = `dma_lock && beat_cnt_n < BURST_MAX`.
- When DMA is not granted, `beat_cnt` and `lock_active` clear.
- `dma_req` falling while `lock_active` ends the tenure; rule 3 no longer matches.
- `cpu_wait` and `dma_wait` are never both nonzero: whenever both request, one of them is granted. Rule 2 precedes rule 3, so CPU starvation breaks a DMA lock.
- `owner` updates only on cycles with a grant.

## Timing
- Grant, `cpu_stall`, `dma_gnt`, `mem_*` and `*_rdata` are combinational from inputs plus registered state, with zero-cycle latency.
- A write commits at the posedge ending the granted cycle. Read data is valid in the same granted cycle.
- Outputs while `reset` = 1: `mem_byteen` = 0, `mem_addr`/`mem_wdata` = 0, `dma_gnt` = 0, `cpu_stall` = 0, `*_rdata` = 0.
- Registered state after the reset edge: all counters 0, `lock_active` = 0, `owner` = 0.
- Reset mid-burst drops the lock. The first post-reset cycle arbitrates from clean state.
- Worst-case consecutive CPU stall is STARVE_LIMIT cycles. Worst-case DMA wait is STARVE_LIMIT cycles when it is not locked out by its own absence.
- A locked DMA tenure lasts at most min(BURST_MAX, STARVE_LIMIT+1) beats while the CPU is requesting.

## Test plan
- **Reset:** `reset`=1 with both req, byteen=4'hf → `mem_byteen`=0, `dma_gnt`=0, `cpu_stall`=0. Release reset with only `cpu_req` → CPU granted with `cpu_wait`=0.
- **CPU-only store:** addr 0x10, wdata 0xdeadbeef, byteen 4'hf → `mem_addr`=0x10, `mem_wdata`=0xdeadbeef, `mem_byteen`=4'hf, `cpu_stall`=0. A following load of 0x10 returns 0xdeadbeef on `cpu_rdata`.
- **Fairness (STARVE_LIMIT=4, no lock):** both request continuously from cycle 0 → CPU wins cycles 0–3, DMA wins cycle 4, CPU wins 5–8, DMA wins 9. `cpu_stall` is high only on cycles 4 and 9.
- **Starvation break (STARVE_LIMIT=4, BURST_MAX=8):** DMA locked from cycle 0, `cpu_req` from cycle 1 → DMA wins cycles 0–4, `cpu_stall` is high on cycles 1–4, CPU wins cycle 5, and `lock_active`=0 afterwards.
- **Burst cap (STARVE_LIMIT=16, BURST_MAX=4):** DMA locked from cycle 0, `cpu_req` from cycle 1 → DMA wins cycles 0–3, CPU wins cycle 4 by rule 5, `cpu_stall` is high on cycles 1–3.
- **Reset mid-burst:** assert `reset` at DMA beat 2 with lock held; deassert with `cpu_req` and `dma_req`/`dma_lock` high → CPU granted on the first post-reset cycle.

Source files
------------

// File: rtl/dbus_arbiter.sv
// Two-master data-port arbiter: CPU M-stage port vs. DMA/debug master.
// Starvation counters and a capped DMA burst lock bound each side's latency.
module dbus_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned BURST_MAX    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_byteen,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_lock,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic [3:0]  dma_byteen,
   output logic        dma_gnt,
   output logic [31:0] dma_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byteen,
   input  logic [31:0] mem_rdata,
   output logic        owner
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned BW = $clog2(BURST_MAX + 1);

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_CPU,
      GNT_DMA
   } gnt_e;

   gnt_e          gnt;
   logic [CW-1:0] cpu_wait, cpu_wait_n;
   logic [CW-1:0] dma_wait, dma_wait_n;
   logic [BW-1:0] beat_cnt, beat_cnt_n;
   logic          lock_active, lock_active_n;

   // Priority chain; CPU starvation is checked before the lock so it can break a burst.
   always_comb begin
      gnt = GNT_NONE;
      if (reset)
         gnt = GNT_NONE;
      else if (cpu_req && cpu_wait == CW'(STARVE_LIMIT))
         gnt = GNT_CPU;
      else if (dma_req && lock_active)
         gnt = GNT_DMA;
      else if (dma_req && dma_wait == CW'(STARVE_LIMIT))
         gnt = GNT_DMA;
      else if (cpu_req)
         gnt = GNT_CPU;
      else if (dma_req)
         gnt = GNT_DMA;
   end

   always_comb begin
      cpu_wait_n    = cpu_wait;
      dma_wait_n    = dma_wait;
      beat_cnt_n    = '0;
      lock_active_n = 1'b0;

      if (!cpu_req || gnt == GNT_CPU)
         cpu_wait_n = '0;
      else if (cpu_wait != CW'(STARVE_LIMIT))
         cpu_wait_n = cpu_wait + CW'(1);

      if (!dma_req || gnt == GNT_DMA)
         dma_wait_n = '0;
      else if (dma_wait != CW'(STARVE_LIMIT))
         dma_wait_n = dma_wait + CW'(1);

      if (gnt == GNT_DMA) begin
         beat_cnt_n    = lock_active ? beat_cnt + BW'(1) : BW'(1);
         lock_active_n = dma_lock && (beat_cnt_n < BW'(BURST_MAX));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_wait    <= '0;
         dma_wait    <= '0;
         beat_cnt    <= '0;
         lock_active <= 1'b0;
         owner       <= 1'b0;
      end else begin
         cpu_wait    <= cpu_wait_n;
         dma_wait    <= dma_wait_n;
         beat_cnt    <= beat_cnt_n;
         lock_active <= lock_active_n;
         if (gnt != GNT_NONE)
            owner <= (gnt == GNT_DMA);
      end
   end

   always_comb begin
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_byteen = '0;
      cpu_rdata  = '0;
      dma_rdata  = '0;
      dma_gnt    = 1'b0;
      cpu_stall  = cpu_req && gnt != GNT_CPU && !reset;
      case (gnt)
         GNT_CPU: begin
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
            mem_byteen = cpu_byteen;
            cpu_rdata  = mem_rdata;
         end
         GNT_DMA: begin
            mem_addr   = dma_addr;
            mem_wdata  = dma_wdata;
            mem_byteen = dma_byteen;
            dma_rdata  = mem_rdata;
            dma_gnt    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
